// File: rtl/nibble_packer.sv
// nibble_packer: packs NIBS nibbles from a valid/ready stream into one wide word.
// The first nibble lands in the top lane (MSB_FIRST=1) or the bottom lane (MSB_FIRST=0).
// A word closes after NIBS nibbles, or earlier on in_last. It is held in a single
// output register with zero-bubble reload.
module nibble_packer #(
  parameter int NIB_W     = 4,
  parameter int NIBS      = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = NIB_W * NIBS,
  localparam int CW       = $clog2(NIBS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NIB_W-1:0] in_nib,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_word,
  output logic [CW-1:0] out_count,
  output logic          out_last
);

  logic [W-1:0]  acc;
  logic [CW-1:0] idx;
  logic [W-1:0]  merged;
  logic          accept;
  logic          complete;

  // The whole pipeline advances only when the output register is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((idx == CW'(NIBS - 1)) || in_last);

  // Merge the incoming nibble into the lane selected by idx.
  always_comb begin
    // NOTE: default assignment first so no path leaves merged unassigned (no latch).
    merged = acc;
    for (int l = 0; l < NIBS; l++) begin
      if (idx == CW'(l)) begin
        if (MSB_FIRST) merged[W-1-l*NIB_W -: NIB_W] = in_nib;
        else           merged[l*NIB_W +: NIB_W]     = in_nib;
      end
    end
  end

  // Accumulator, lane index and output register; all frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the accumulator is a register, not a memory, so it is reset. Reset is what
    // discards a partial word.
    if (!rst_n) begin
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      out_valid <= complete;
      if (complete) begin
        out_word  <= merged;
        out_count <= idx + CW'(1);
        out_last  <= in_last;
        acc       <= '0;
        idx       <= '0;
      end else if (accept) begin
        acc <= merged;
        idx <= idx + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer.
// The main instance is MSB-first. A second, LSB-first instance shares its inputs.
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nib;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [2:0]  out_count;
  logic        out_last;

  logic        lsb_in_ready;
  logic        lsb_out_valid;
  logic [15:0] lsb_out_word;
  logic [2:0]  lsb_out_count;
  logic        lsb_out_last;

  int checks = 0;
  int errors = 0;

  // Free-running clock with rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  nibble_packer #(.NIB_W(4), .NIBS(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_nib(in_nib), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_count(out_count), .out_last(out_last)
  );

  nibble_packer #(.NIB_W(4), .NIBS(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(lsb_in_ready), .in_nib(in_nib), .in_last(in_last),
    .out_valid(lsb_out_valid), .out_ready(out_ready), .out_word(lsb_out_word),
    .out_count(lsb_out_count), .out_last(lsb_out_last)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one nibble for one cycle, then sample 1 time unit after the edge.
  task automatic send(input logic [3:0] nib, input logic last);
    in_valid = 1'b1;
    in_nib   = nib;
    in_last  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] seen_word [2];
  int          seen_cyc  [2];
  int          valid_cnt;
  int          ready_drops;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_nib    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word",  out_word,  0);
    check("rst_out_count", out_count, 0);
    check("rst_out_last",  out_last,  0);
    check("rst_in_ready",  in_ready,  1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full word, MSB-first and LSB-first
    send(4'hD, 1'b0);
    send(4'h5, 1'b0);
    send(4'hA, 1'b0);
    check("t1_no_early_valid", out_valid, 0);
    send(4'hF, 1'b0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_word",  out_word,  16'hD5AF);
    check("t1_out_count", out_count, 4);
    check("t1_out_last",  out_last,  0);
    check("t1_lsb_word",  lsb_out_word,  16'hFA5D);
    check("t1_lsb_count", lsb_out_count, 4);
    idle();
    check("t1_drained", out_valid, 0);

    // Early close on in_last, followed directly by a full word
    send(4'h1, 1'b0);
    send(4'h2, 1'b1);
    check("t3_short_valid", out_valid, 1);
    check("t3_short_word",  out_word,  16'h1200);
    check("t3_short_count", out_count, 2);
    check("t3_short_last",  out_last,  1);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    check("t3_full_word",  out_word,  16'h3456);
    check("t3_full_count", out_count, 4);
    check("t3_full_last",  out_last,  0);
    idle();

    // Backpressure
    send(4'hD, 1'b0);
    send(4'h5, 1'b0);
    send(4'hA, 1'b0);
    send(4'hF, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_nib    = 4'h0;
    in_last   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_word",  out_word,  16'hD5AF);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_consumed", out_valid, 0);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_word",  out_word,  16'h0123);

    // Throughput: eight nibbles back-to-back while the previous word drains
    valid_cnt   = 0;
    ready_drops = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_nib   = 4'(i);
      in_last  = 1'b0;
      #1;
      if (!in_ready) ready_drops++;
      @(posedge clk); #1;
      if (out_valid) begin
        if (valid_cnt < 2) begin
          seen_word[valid_cnt] = out_word;
          seen_cyc[valid_cnt]  = i;
        end
        valid_cnt++;
      end
    end
    check("tp_ready_drops", ready_drops, 0);
    check("tp_valid_cycles", valid_cnt, 2);
    check("tp_word0", seen_word[0], 16'h0123);
    check("tp_word1", seen_word[1], 16'h4567);
    check("tp_gap", seen_cyc[1] - seen_cyc[0], 4);
    idle();

    // Asynchronous reset mid-word
    send(4'h9, 1'b0);
    send(4'h9, 1'b0);
    send(4'h9, 1'b0);
    in_valid = 1'b0;
    check("rm_word_held", out_word, 16'h4567);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_out_valid", out_valid, 0);
    check("rm_out_word",  out_word,  0);
    check("rm_out_count", out_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    send(4'hC, 1'b0);
    send(4'hD, 1'b0);
    check("rm_valid", out_valid, 1);
    check("rm_word",  out_word,  16'hABCD);
    check("rm_count", out_count, 4);
    check("rm_last",  out_last,  0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Downstream consumer of the byte-slicing stage.
- Accepts a stream of 4-bit slices (nibbles) over a valid/ready handshake and packs NIBS of them into one wide word.
- Nibbles are placed into lanes with indexed part-selects, either MSB-first (-:) or LSB-first (+:).
- Emits the packed word over a registered valid/ready output. A word closes early on in_last.

Parameters:
- NIB_W, 4, width of one input nibble/slice.
- NIBS, 4, nibbles per output word; output word width W = NIB_W*NIBS (default 16).
- MSB_FIRST, 1, 1: first nibble lands in lane [W-1 -: NIB_W]; 0: first nibble lands in lane [0 +: NIB_W].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  nibble present on in_nib.
- in_ready  output  1  packer accepts nibble this cycle.
- in_nib  input  NIB_W  nibble data.
- in_last  input  1  accepted nibble closes current word (frame end).
- out_valid  output  1  out_word/out_count/out_last valid.
- out_ready  input  1  consumer accepts word.
- out_word  output  W  packed word; unfilled lanes are zero.
- out_count  output  $clog2(NIBS+1)  number of valid nibbles in out_word (1..NIBS).
- out_last  output  1  word was closed by in_last.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_word=0, out_count=0, out_last=0, lane index idx=0, accumulator=0.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). No combinational path from in_valid to out_valid.
- Lane placement on accept, lane idx:
  - MSB_FIRST=1: acc[W-1-idx*NIB_W -: NIB_W] = in_nib.
  - MSB_FIRST=0: acc[idx*NIB_W +: NIB_W] = in_nib.
- Word completion: an accept with idx==NIBS-1 or in_last=1 completes the word. On the next edge:
  - out_word = acc with the new nibble merged.
  - out_count = idx+1; out_last = in_last.
  - out_valid = 1; acc cleared to 0; idx = 0.
- Non-completing accept: idx increments; output regs are unchanged.
- Latency: 1 cycle from the completing accept to out_valid=1.
- States: COLLECT (idx 0..NIBS-1) and output register FULL/EMPTY.
  - FULL && !out_ready: in_ready=0 and the entire pipeline stalls, including partial accumulation.
  - FULL && out_ready && completing accept in the same cycle: out regs reload with the new word and out_valid stays 1, giving zero-bubble streaming.
  - FULL && out_ready && no completion: out_valid -> 0.
- Output stability: out_word/out_count/out_last hold while out_valid && !out_ready.
- in_last on the first nibble: word with out_count=1 and only that lane populated.
- in_last with idx==NIBS-1: a single full word with out_last=1. No extra empty word is produced.
- in_valid is ignored while in_ready=0. in_nib/in_last are don't-care when in_valid=0.
- Reset mid-word: the partial accumulation is discarded, with no output for it. Packing restarts at lane 0 after release.

Test Plan:
- MSB_FIRST=1, out_ready=1, nibbles D,5,A,F back-to-back, in_last=0 -> one cycle after F: out_valid=1, out_word=16'hD5AF, out_count=4, out_last=0.
- MSB_FIRST=0, same stimulus -> out_word=16'hFA5D, out_count=4.
- MSB_FIRST=1, nibbles 1,2 with in_last on 2 -> out_word=16'h1200, out_count=2, out_last=1. Then nibbles 3,4,5,6 -> out_word=16'h3456, out_last=0.
- Backpressure: out_ready=0 after first word 16'hD5AF:
  - in_ready=0 and out_word holds for 5 cycles.
  - Raise out_ready -> word consumed, in_ready=1 in the same cycle.
  - Next 4 nibbles 0,1,2,3 -> 16'h0123.
- Throughput: 8 consecutive nibbles 0..7 with out_ready=1 -> in_ready never drops; words 16'h0123 then 16'h4567, with out_valid high on two cycles, separated by 3 cycles.
- Reset mid-word: accept 9,9,9, pulse rst_n low asynchronously between edges -> outputs zero immediately. After release, nibbles A,B,C,D -> out_word=16'hABCD, count 4, with no 9 lanes present.
